// File: rtl/tile_cfg_pkg.sv
// Shared state type, header field layout and elaboration helpers for the tile config loader.
package tile_cfg_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, FWD, DROP} cfg_state_e;

  // Only the low ID_W bits are compared against the header id.
  localparam logic [63:0] BROADCAST_ID = '1;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int row_w_f(input int num_wl);
    return (clog2_f(num_wl) < 1) ? 1 : clog2_f(num_wl);
  endfunction

  function automatic int hdr_id_lsb();
    return 0;
  endfunction

  function automatic int hdr_row_lsb(input int id_w);
    return id_w;
  endfunction

endpackage

// File: rtl/cfg_out_stage.sv
// One-entry valid/ready register slice used to forward config words to the next tile.
module cfg_out_stage
  import tile_cfg_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  // Accepting while the held word drains gives one word per cycle.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (out_ready) valid_d = 1'b0;
    if (in_valid && in_ready) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/tile_cfg_frame_loader.sv
// Claims config packets addressed to TILE_ID, writes one bit-line row and forwards the rest.
// Define TILE_CFG_BROADCAST_EN to also load and forward packets with the all-ones id.
module tile_cfg_frame_loader
  import tile_cfg_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int BL_WIDTH = 80,
  parameter int NUM_WL   = 4,
  parameter int ID_W     = 8,
  parameter int TILE_ID  = 0,
  parameter int WL_PULSE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] cfg_in_data,
  input  logic              cfg_in_valid,
  input  logic              cfg_in_last,
  output logic              cfg_in_ready,
  output logic [WORD_W-1:0] cfg_out_data,
  output logic              cfg_out_valid,
  output logic              cfg_out_last,
  input  logic              cfg_out_ready,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:NUM_WL-1]   wl,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [15:0]       frame_cnt
);

  localparam int ROW_W       = row_w_f(NUM_WL);
  localparam int FRAME_WORDS = ceil_div(BL_WIDTH, WORD_W);
  localparam int K_W         = (clog2_f(FRAME_WORDS) < 1) ? 1 : clog2_f(FRAME_WORDS);
  localparam int P_W         = clog2_f(WL_PULSE + 1);
  localparam int ID_LSB      = hdr_id_lsb();
  localparam int ROW_LSB     = hdr_row_lsb(ID_W);

  if (WORD_W < ID_W + ROW_W) begin : g_bad_cfg
    $error("tile_cfg_frame_loader: WORD_W must be at least ID_W + ROW_W");
  end

  cfg_state_e          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [P_W-1:0]      pcnt_q, pcnt_d;
  logic [0:BL_WIDTH-1] bl_buf_q, bl_buf_d;
  logic [0:BL_WIDTH-1] bl_q, bl_d;
  logic [0:NUM_WL-1]   wl_q, wl_d;
  logic                bcast_q, bcast_d;
  logic                live_q, live_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic [ID_W-1:0]  hdr_id;
  logic [ROW_W-1:0] hdr_row;
  logic             hdr_match, hdr_bcast, hdr_local, hdr_row_ok;
  logic             os_free, os_in_valid, in_ready, in_xfer;

  assign hdr_id     = cfg_in_data[ID_LSB +: ID_W];
  assign hdr_row    = cfg_in_data[ROW_LSB +: ROW_W];
  assign hdr_match  = (hdr_id == ID_W'(TILE_ID));
  assign hdr_row_ok = (int'(hdr_row) < NUM_WL);
`ifdef TILE_CFG_BROADCAST_EN
  assign hdr_bcast  = (hdr_id == BROADCAST_ID[ID_W-1:0]);
`else
  assign hdr_bcast  = 1'b0;
`endif
  assign hdr_local  = hdr_match || hdr_bcast;

  // IDLE waits for a free out stage since the header may have to be forwarded.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, FWD: in_ready = os_free;
      LOAD:      in_ready = bcast_q ? os_free : 1'b1;
      DROP:      in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase
    in_ready = in_ready && live_q;
  end

  assign in_xfer = cfg_in_valid && in_ready;
  assign live_d  = 1'b1;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    k_d         = k_q;
    pcnt_d      = pcnt_q;
    bl_buf_d    = bl_buf_q;
    bl_d        = bl_q;
    wl_d        = wl_q;
    bcast_d     = bcast_q;
    cfg_done_d  = 1'b0;
    cfg_err_d   = cfg_err_q;
    frame_cnt_d = frame_cnt_q;
    os_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (hdr_local) begin
            if (hdr_row_ok && !cfg_in_last) begin
              state_d = LOAD;
              k_d     = '0;
              row_d   = hdr_row;
              bcast_d = hdr_bcast;
            end else begin
              cfg_err_d = 1'b1;
              state_d   = cfg_in_last ? IDLE : (hdr_bcast ? FWD : DROP);
            end
          end
          if (!hdr_local || hdr_bcast) begin
            os_in_valid = 1'b1;
            if (!hdr_local) state_d = cfg_in_last ? IDLE : FWD;
          end
        end
      end
      LOAD: begin
        if (in_xfer) begin
          os_in_valid = bcast_q;
          // Bits beyond BL_WIDTH in the final word have no slot and are dropped.
          for (int b = 0; b < BL_WIDTH; b++) begin
            if (k_q == K_W'(b / WORD_W)) bl_buf_d[b] = cfg_in_data[b % WORD_W];
          end
          if (k_q == K_W'(FRAME_WORDS - 1)) begin
            if (cfg_in_last) begin
              state_d = WRITE;
              bl_d    = bl_buf_d;
              pcnt_d  = '0;
            end else begin
              cfg_err_d = 1'b1;
              state_d   = bcast_q ? FWD : DROP;
            end
          end else if (cfg_in_last) begin
            cfg_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      WRITE: begin
        // bl was loaded on entry, so the word line rises one cycle later.
        if (pcnt_q == '0) begin
          wl_d         = '0;
          wl_d[row_q]  = 1'b1;
          pcnt_d       = pcnt_q + P_W'(1);
        end else if (pcnt_q != P_W'(WL_PULSE)) begin
          pcnt_d = pcnt_q + P_W'(1);
        end else begin
          wl_d       = '0;
          cfg_done_d = 1'b1;
          if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      FWD: begin
        if (in_xfer) begin
          os_in_valid = 1'b1;
          if (cfg_in_last) state_d = IDLE;
        end
      end
      DROP: begin
        if (in_xfer && cfg_in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      k_q         <= '0;
      pcnt_q      <= '0;
      bl_buf_q    <= '0;
      bl_q        <= '0;
      wl_q        <= '0;
      bcast_q     <= 1'b0;
      live_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      k_q         <= k_d;
      pcnt_q      <= pcnt_d;
      bl_buf_q    <= bl_buf_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      bcast_q     <= bcast_d;
      live_q      <= live_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  cfg_out_stage #(.WORD_W(WORD_W)) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .in_data   (cfg_in_data),
    .in_valid  (os_in_valid),
    .in_last   (cfg_in_last),
    .in_ready  (os_free),
    .out_data  (cfg_out_data),
    .out_valid (cfg_out_valid),
    .out_last  (cfg_out_last),
    .out_ready (cfg_out_ready)
  );

  assign cfg_in_ready = in_ready;
  assign bl           = bl_q;
  assign wl           = wl_q;
  assign cfg_done     = cfg_done_q;
  assign cfg_err      = cfg_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_tile_cfg_frame_loader.sv
// Directed bench for tile_cfg_frame_loader; a second instance with NUM_WL=3 covers the bad-row case.
module tb_tile_cfg_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_last, out_ready;
  logic [0:79] bl;
  logic [0:3]  wl;
  logic        done, err;
  logic [15:0] fcnt;

  logic [31:0] b_in_data;
  logic        b_in_valid, b_in_last, b_in_ready;
  logic [31:0] b_out_data;
  logic        b_out_valid, b_out_last;
  logic [0:79] b_bl;
  logic [0:2]  b_wl;
  logic        b_done, b_err;
  logic [15:0] b_fcnt;

  logic tog_en;
  logic tog = 1'b1;
  int   tests = 0;
  int   fails = 0;

  assign out_ready = tog_en ? tog : 1'b1;

  always #5 clk = ~clk;

  tile_cfg_frame_loader dut (
    .clk(clk), .reset(reset),
    .cfg_in_data(in_data), .cfg_in_valid(in_valid), .cfg_in_last(in_last), .cfg_in_ready(in_ready),
    .cfg_out_data(out_data), .cfg_out_valid(out_valid), .cfg_out_last(out_last), .cfg_out_ready(out_ready),
    .bl(bl), .wl(wl), .cfg_done(done), .cfg_err(err), .frame_cnt(fcnt)
  );

  tile_cfg_frame_loader #(.NUM_WL(3)) dut_b (
    .clk(clk), .reset(reset),
    .cfg_in_data(b_in_data), .cfg_in_valid(b_in_valid), .cfg_in_last(b_in_last), .cfg_in_ready(b_in_ready),
    .cfg_out_data(b_out_data), .cfg_out_valid(b_out_valid), .cfg_out_last(b_out_last), .cfg_out_ready(1'b1),
    .bl(b_bl), .wl(b_wl), .cfg_done(b_done), .cfg_err(b_err), .frame_cnt(b_fcnt)
  );

  // Downstream ready alternates 1,0,1,... while tog_en is set.
  always begin
    @(posedge clk);
    #2;
    if (tog_en) tog = ~tog;
    else tog = 1'b1;
  end

  logic [32:0] out_log [0:63];
  logic [0:3]  wl_last = '0;
  int out_cnt = 0, wl_cycles = 0, done_cnt = 0, b_out_cnt = 0, b_wl_cycles = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready && out_cnt < 64) begin
      out_log[out_cnt] = {out_last, out_data};
      out_cnt++;
    end
    if (|wl) begin
      wl_cycles++;
      wl_last = wl;
    end
    if (done) done_cnt++;
    if (b_out_valid) b_out_cnt++;
    if (|b_wl || b_done) b_wl_cycles++;
  end

  function automatic logic [0:79] to_bl(input logic [79:0] v);
    logic [0:79] r;
    for (int i = 0; i < 80; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one word and holds it until the handshake completes; returns #1 after the transfer edge.
  task automatic send(input bit to_b, input logic [31:0] d, input logic l);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    if (to_b) begin b_in_data = d; b_in_last = l; b_in_valid = 1'b1; end
    else begin in_data = d; in_last = l; in_valid = 1'b1; end
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = to_b ? b_in_ready : in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (to_b) b_in_valid = 1'b0;
    else in_valid = 1'b0;
    check("send_accepted", {79'd0, ok}, 80'd1);
  endtask

  initial begin
    logic [0:79] exp_bl;
    int exp_fcnt, base_o, base_w, base_d;
    reset = 1'b1; tog_en = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bl", bl, 0);
    check("rst_wl", wl, 0);
    check("rst_err_done_cnt", {err, done, fcnt}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", in_ready, 1);
    check("b_ready_after_rst", b_in_ready, 1);

    // Local write of row 2
    send(0, 32'h0000_0200, 0);
    send(0, 32'h1111_1111, 0);
    send(0, 32'h2222_2222, 0);
    send(0, 32'h0000_3333, 1);
    exp_bl = to_bl(80'h3333_2222_2222_1111_1111);
    exp_fcnt = 1;
    check("wr_bl", bl, exp_bl);
    check("wr_wl_pre", wl, 0);
    check("wr_ready_stall", in_ready, 0);
    @(posedge clk); #1;
    check("wr_wl_c1", wl, 4'b0010);
    @(posedge clk); #1;
    check("wr_wl_c2", wl, 4'b0010);
    check("wr_done_early", done, 0);
    @(posedge clk); #1;
    check("wr_wl_fall", wl, 0);
    check("wr_done", done, 1);
    check("wr_fcnt", fcnt, 1);
    @(posedge clk); #1;
    check("wr_done_1cyc", done, 0);
    check("wr_ready_back", in_ready, 1);

    // Bad row on the 3-row instance
    send(1, 32'h0000_0300, 0);
    send(1, 32'h0000_0001, 0);
    send(1, 32'h0000_0002, 0);
    send(1, 32'h0000_0003, 1);
    repeat (4) @(posedge clk);
    #1;
    check("badrow_err", b_err, 1);
    check("badrow_fwd", b_out_cnt, 0);
    check("badrow_wl_done", b_wl_cycles, 0);
    check("badrow_fcnt", b_fcnt, 0);
    check("badrow_bl", b_bl, 0);
    check("badrow_ready", b_in_ready, 1);
    check("badrow_out", {b_out_valid, b_out_last, b_out_data}, 0);

    // Forward to tile 5 with toggling downstream ready
    base_o = out_cnt; base_w = wl_cycles;
    tog_en = 1'b1;
    send(0, 32'h0000_0005, 0);
    send(0, 32'hA1A1_0001, 0);
    send(0, 32'hA2A2_0002, 0);
    send(0, 32'hA3A3_0003, 1);
    for (int n = 0; n < 20 && out_cnt < base_o + 4; n++) begin
      @(posedge clk); #1;
    end
    tog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fwd_count", out_cnt - base_o, 4);
    check("fwd_w0", out_log[base_o], {1'b0, 32'h0000_0005});
    check("fwd_w1", out_log[base_o+1], {1'b0, 32'hA1A1_0001});
    check("fwd_w2", out_log[base_o+2], {1'b0, 32'hA2A2_0002});
    check("fwd_w3", out_log[base_o+3], {1'b1, 32'hA3A3_0003});
    check("fwd_no_wl", wl_cycles - base_w, 0);
    check("fwd_out_idle", out_valid, 0);

`ifdef TILE_CFG_BROADCAST_EN
    // Broadcast: local row-3 write and full forward
    base_o = out_cnt; base_w = wl_cycles; base_d = done_cnt;
    send(0, 32'h0000_03FF, 0);
    send(0, 32'h5555_5555, 0);
    send(0, 32'h6666_6666, 0);
    send(0, 32'h0000_7777, 1);
    for (int n = 0; n < 20 && done_cnt == base_d; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    exp_bl = to_bl(80'h7777_6666_6666_5555_5555);
    exp_fcnt++;
    check("bc_count", out_cnt - base_o, 4);
    check("bc_w0", out_log[base_o], {1'b0, 32'h0000_03FF});
    check("bc_w3", out_log[base_o+3], {1'b1, 32'h0000_7777});
    check("bc_wl_row", wl_last, 4'b0001);
    check("bc_wl_len", wl_cycles - base_w, 2);
    check("bc_bl", bl, exp_bl);
    check("bc_fcnt", fcnt, exp_fcnt);
`else
    // All-ones id is an ordinary foreign id
    base_o = out_cnt; base_w = wl_cycles;
    send(0, 32'h0000_03FF, 0);
    send(0, 32'hCAFE_0000, 1);
    repeat (4) @(posedge clk);
    #1;
    check("ff_count", out_cnt - base_o, 2);
    check("ff_w0", out_log[base_o], {1'b0, 32'h0000_03FF});
    check("ff_w1", out_log[base_o+1], {1'b1, 32'hCAFE_0000});
    check("ff_no_wl", wl_cycles - base_w, 0);
    check("ff_fcnt", fcnt, exp_fcnt);
`endif
    check("err_clean", err, 0);

    // Short packet, then a valid packet still writes
    base_w = wl_cycles; base_d = done_cnt;
    send(0, 32'h0000_0100, 0);
    send(0, 32'h0000_DEAD, 1);
    repeat (4) @(posedge clk);
    #1;
    check("short_err", err, 1);
    check("short_bl", bl, exp_bl);
    check("short_no_wl", wl_cycles - base_w, 0);
    check("short_no_done", done_cnt - base_d, 0);
    send(0, 32'h0000_0300, 0);
    send(0, 32'h0F0F_0F0F, 0);
    send(0, 32'hF0F0_F0F0, 0);
    send(0, 32'hFFFF_ABCD, 1);
    for (int n = 0; n < 10 && done_cnt == base_d; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    exp_bl = to_bl(80'hABCD_F0F0_F0F0_0F0F_0F0F);
    exp_fcnt++;
    check("after_err_bl", bl, exp_bl);
    check("after_err_wl_row", wl_last, 4'b0001);
    check("after_err_wl_len", wl_cycles - base_w, 2);
    check("after_err_fcnt", fcnt, exp_fcnt);
    check("err_sticky", err, 1);

    // Reset during the first WRITE cycle of a row-0 write
    send(0, 32'h0000_0000, 0);
    send(0, 32'h0000_0001, 0);
    send(0, 32'h0000_0002, 0);
    send(0, 32'h0000_0003, 1);
    base_w = wl_cycles; base_d = done_cnt;
    check("rst_mid_in_write", in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_wl", wl, 0);
    check("rst_mid_fcnt", fcnt, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - base_d, 0);
    check("rst_mid_no_wl", wl_cycles - base_w, 0);
    check("rst_mid_fcnt_hold", fcnt, 0);
    check("rst_mid_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
